// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin share of one combinational binary-to-BCD converter
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req[2:0]         level requests, bit i = requester i
//   val0..val2[7:0]  value to convert per requester
//   gnt[2:0]         one-hot single-cycle grant pulse
//   dd_in[7:0]       registered drive to the shared converter input
//   dd_out[11:0]     converter result {hundreds, tens, ones}
//   bcd_out[11:0]    captured BCD result, held between bcd_valid pulses
//   bcd_neg          sign of captured value (0 unless BCD_SIGNED_EN)
//   bcd_id[1:0]      requester owning bcd_out
//   bcd_valid        single-cycle result strobe
//   busy             conversion in flight
// Optional feature macro: BCD_SIGNED_EN (two's complement inputs, magnitude converted)
module bcd_convert_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [7:0]  val0,
   input  logic [7:0]  val1,
   input  logic [7:0]  val2,
   output logic [2:0]  gnt,
   output logic [7:0]  dd_in,
   input  logic [11:0] dd_out,
   output logic [11:0] bcd_out,
   output logic        bcd_neg,
   output logic [1:0]  bcd_id,
   output logic        bcd_valid,
   output logic        busy
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [1:0]  last, last_n;
   logic [2:0]  gnt_n;
   logic [7:0]  dd_in_n;
   logic        sign_q, sign_n;
   logic [11:0] bcd_out_n;
   logic [1:0]  bcd_id_n;
   logic        bcd_neg_n;
   logic        bcd_valid_n;
   logic [1:0]  p1, p2, win;
   logic [7:0]  sel, mag;
   logic        neg;
   // search order last+1, last+2, last (mod 3)
   assign p1  = (last == 2'd2) ? 2'd0 : last + 2'd1;
   assign p2  = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
   assign win = req[p1] ? p1 : req[p2] ? p2 : last;
   assign sel = (win == 2'd0) ? val0 : (win == 2'd1) ? val1 : val2;
`ifdef BCD_SIGNED_EN
   assign mag = sel[7] ? ~sel + 8'd1 : sel;
   assign neg = sel[7];
`else
   assign mag = sel;
   assign neg = 1'b0;
`endif
   assign busy = (state == WAIT);
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      last_n      = last;
      gnt_n       = 3'b000;
      dd_in_n     = dd_in;
      sign_n      = sign_q;
      bcd_out_n   = bcd_out;
      bcd_id_n    = bcd_id;
      bcd_neg_n   = bcd_neg;
      bcd_valid_n = 1'b0;
      if (state == IDLE) begin
         if (|req) begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
            last_n  = win;
            gnt_n   = 3'b001 << win;
            dd_in_n = mag;
            sign_n  = neg;
         end
      end else if (cnt == 4'd0) begin
         state_n     = IDLE;
         bcd_out_n   = dd_out;
         bcd_id_n    = last;
         bcd_neg_n   = sign_q;
         bcd_valid_n = 1'b1;
      end else begin
         cnt_n = cnt - 4'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last      <= 2'd2;
         gnt       <= 3'b000;
         dd_in     <= 8'd0;
         sign_q    <= 1'b0;
         bcd_out   <= 12'd0;
         bcd_id    <= 2'd0;
         bcd_neg   <= 1'b0;
         bcd_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         last      <= last_n;
         gnt       <= gnt_n;
         dd_in     <= dd_in_n;
         sign_q    <= sign_n;
         bcd_out   <= bcd_out_n;
         bcd_id    <= bcd_id_n;
         bcd_neg   <= bcd_neg_n;
         bcd_valid <= bcd_valid_n;
      end
   end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed bench for bcd_convert_arbiter (settle 1 and settle 3 instances)
module tb_bcd_convert_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = 3'b000, req3 = 3'b000;
   logic [7:0]  val0 = 8'd0, val1 = 8'd0, val2 = 8'd0;
   logic [7:0]  v30 = 8'd0, v31 = 8'd0, v32 = 8'd0;
   logic [2:0]  gnt, gnt3;
   logic [7:0]  dd_in, dd_in3;
   logic [11:0] dd_out, dd_out3, bcd_out, bcd_out3;
   logic        bcd_neg, bcd_neg3, bcd_valid, bcd_valid3, busy, busy3;
   logic [1:0]  bcd_id, bcd_id3;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input logic [7:0] v);
      return {4'(v / 8'd100), 4'((v / 8'd10) % 8'd10), 4'(v % 8'd10)};
   endfunction

   assign dd_out  = to_bcd(dd_in);
   assign dd_out3 = to_bcd(dd_in3);

   bcd_convert_arbiter #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .val0(val0), .val1(val1), .val2(val2),
      .gnt(gnt), .dd_in(dd_in), .dd_out(dd_out), .bcd_out(bcd_out), .bcd_neg(bcd_neg),
      .bcd_id(bcd_id), .bcd_valid(bcd_valid), .busy(busy));

   bcd_convert_arbiter #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .val0(v30), .val1(v31), .val2(v32),
      .gnt(gnt3), .dd_in(dd_in3), .dd_out(dd_out3), .bcd_out(bcd_out3), .bcd_neg(bcd_neg3),
      .bcd_id(bcd_id3), .bcd_valid(bcd_valid3), .busy(busy3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({gnt, dd_in, bcd_out, bcd_neg, bcd_id, bcd_valid, busy} !== 29'd0) begin
         failures++;
         $display("FAIL reset_outputs: got gnt=%b dd_in=%h bcd_out=%h neg=%b id=%0d valid=%b busy=%b expected all 0",
                  gnt, dd_in, bcd_out, bcd_neg, bcd_id, bcd_valid, busy);
      end
      checks++;
      if ({gnt3, dd_in3, bcd_out3, bcd_valid3, busy3} !== 25'd0) begin
         failures++;
         $display("FAIL reset_outputs3: got gnt=%b dd_in=%h bcd_out=%h valid=%b busy=%b expected all 0",
                  gnt3, dd_in3, bcd_out3, bcd_valid3, busy3);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      req = 3'b010;
      val1 = 8'd255;
      tick();
      checks++;
      if ({gnt, busy, bcd_valid, dd_in} !== {3'b010, 1'b1, 1'b0, 8'd255}) begin
         failures++;
         $display("FAIL single_grant: got gnt=%b busy=%b valid=%b dd_in=%0d expected gnt=010 busy=1 valid=0 dd_in=255",
                  gnt, busy, bcd_valid, dd_in);
      end
      req = 3'b000;
      tick();
      checks++;
      if ({gnt, busy, bcd_valid, bcd_out, bcd_id, bcd_neg} !== {3'b000, 1'b0, 1'b1, 12'h255, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL single_result: got gnt=%b busy=%b valid=%b bcd=%h id=%0d neg=%b expected 000 0 1 255 1 0",
                  gnt, busy, bcd_valid, bcd_out, bcd_id, bcd_neg);
      end
      tick();
      checks++;
      if ({bcd_valid, bcd_out, bcd_id, busy} !== {1'b0, 12'h255, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL single_hold: got valid=%b bcd=%h id=%0d busy=%b expected 0 255 1 0",
                  bcd_valid, bcd_out, bcd_id, busy);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_g[3] = '{3'b001, 3'b010, 3'b100};
      logic [11:0] exp_b[3] = '{12'h010, 12'h020, 12'h030};
      do_reset();
      val0 = 8'd10;
      val1 = 8'd20;
      val2 = 8'd30;
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({gnt, bcd_valid} !== {exp_g[i], 1'b0}) begin
            failures++;
            $display("FAIL rr_grant%0d: got gnt=%b valid=%b expected gnt=%b valid=0", i, gnt, bcd_valid, exp_g[i]);
         end
         req[i] = 1'b0;
         tick();
         checks++;
         if ({gnt, bcd_valid, bcd_out, bcd_id} !== {3'b000, 1'b1, exp_b[i], 2'(i)}) begin
            failures++;
            $display("FAIL rr_result%0d: got gnt=%b valid=%b bcd=%h id=%0d expected 000 1 %h %0d",
                     i, gnt, bcd_valid, bcd_out, bcd_id, exp_b[i], i);
         end
      end
   endtask

   task automatic test_alternate();
      logic [2:0] exp_g[4] = '{3'b001, 3'b100, 3'b001, 3'b100};
      val0 = 8'd1;
      val1 = 8'd2;
      val2 = 8'd3;
      req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({gnt, bcd_valid} !== {exp_g[i], 1'b0}) begin
            failures++;
            $display("FAIL alt_grant%0d: got gnt=%b valid=%b expected gnt=%b valid=0", i, gnt, bcd_valid, exp_g[i]);
         end
         if (i == 3) req = 3'b000;
         tick();
         checks++;
         if ({gnt, bcd_valid, bcd_id} !== {3'b000, 1'b1, exp_g[i][2], 1'b0}) begin
            failures++;
            $display("FAIL alt_result%0d: got gnt=%b valid=%b id=%0d expected 000 1 %0d",
                     i, gnt, bcd_valid, bcd_id, exp_g[i][2] ? 2 : 0);
         end
      end
      tick();
   endtask

   task automatic test_settle3();
      logic [7:0]  vals[2]  = '{8'd99, 8'd0};
      logic [11:0] exp_b[2] = '{12'h099, 12'h000};
      for (int k = 0; k < 2; k++) begin
         v30 = vals[k];
         req3 = 3'b001;
         tick();
         checks++;
         if ({gnt3, busy3, bcd_valid3, dd_in3} !== {3'b001, 1'b1, 1'b0, vals[k]}) begin
            failures++;
            $display("FAIL s3_grant%0d: got gnt=%b busy=%b valid=%b dd_in=%0d expected 001 1 0 %0d",
                     k, gnt3, busy3, bcd_valid3, dd_in3, vals[k]);
         end
         req3 = 3'b000;
         v30 = 8'd77;
         for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if ({gnt3, busy3, bcd_valid3, dd_in3} !== {3'b000, 1'b1, 1'b0, vals[k]}) begin
               failures++;
               $display("FAIL s3_wait%0d_%0d: got gnt=%b busy=%b valid=%b dd_in=%0d expected 000 1 0 %0d",
                        k, c, gnt3, busy3, bcd_valid3, dd_in3, vals[k]);
            end
         end
         tick();
         checks++;
         if ({busy3, bcd_valid3, bcd_out3, bcd_id3, dd_in3} !== {1'b0, 1'b1, exp_b[k], 2'd0, vals[k]}) begin
            failures++;
            $display("FAIL s3_result%0d: got busy=%b valid=%b bcd=%h id=%0d dd_in=%0d expected 0 1 %h 0 %0d",
                     k, busy3, bcd_valid3, bcd_out3, bcd_id3, dd_in3, exp_b[k], vals[k]);
         end
      end
      tick();
   endtask

   task automatic test_signed();
      logic [7:0]  vals[3] = '{8'hF6, 8'h80, 8'h05};
`ifdef BCD_SIGNED_EN
      logic [11:0] exp_b[3] = '{12'h010, 12'h128, 12'h005};
      logic        exp_n[3] = '{1'b1, 1'b1, 1'b0};
`else
      logic [11:0] exp_b[3] = '{12'h246, 12'h128, 12'h005};
      logic        exp_n[3] = '{1'b0, 1'b0, 1'b0};
`endif
      for (int k = 0; k < 3; k++) begin
         val0 = vals[k];
         req = 3'b001;
         tick();
         req = 3'b000;
         tick();
         checks++;
         if ({bcd_valid, bcd_out, bcd_neg} !== {1'b1, exp_b[k], exp_n[k]}) begin
            failures++;
            $display("FAIL sign%0d: got valid=%b bcd=%h neg=%b expected 1 %h %b",
                     k, bcd_valid, bcd_out, bcd_neg, exp_b[k], exp_n[k]);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      val0 = 8'd4;
      val1 = 8'd7;
      val2 = 8'd9;
      req = 3'b010;
      tick();
      checks++;
      if ({gnt, busy} !== {3'b010, 1'b1}) begin
         failures++;
         $display("FAIL mid_grant: got gnt=%b busy=%b expected 010 1", gnt, busy);
      end
      req = 3'b000;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt, dd_in, bcd_out, bcd_neg, bcd_id, bcd_valid, busy} !== 29'd0) begin
         failures++;
         $display("FAIL mid_reset: got gnt=%b dd_in=%h bcd_out=%h neg=%b id=%0d valid=%b busy=%b expected all 0",
                  gnt, dd_in, bcd_out, bcd_neg, bcd_id, bcd_valid, busy);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bcd_valid, busy, gnt} !== 5'd0) begin
            failures++;
            $display("FAIL mid_no_valid%0d: got valid=%b busy=%b gnt=%b expected 0 0 000", c, bcd_valid, busy, gnt);
         end
      end
      req = 3'b101;
      tick();
      checks++;
      if (gnt !== 3'b001) begin
         failures++;
         $display("FAIL post_reset_first: got gnt=%b expected 001", gnt);
      end
      req = 3'b100;
      tick();
      tick();
      checks++;
      if (gnt !== 3'b100) begin
         failures++;
         $display("FAIL post_reset_req2: got gnt=%b expected 100", gnt);
      end
      req = 3'b000;
      tick();
      checks++;
      if ({bcd_valid, bcd_out, bcd_id} !== {1'b1, 12'h009, 2'd2}) begin
         failures++;
         $display("FAIL post_reset_result: got valid=%b bcd=%h id=%0d expected 1 009 2", bcd_valid, bcd_out, bcd_id);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_alternate();
      test_settle3();
      test_signed();
      test_reset_mid();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_convert_arbiter.md
# bcd_convert_arbiter

Shares one combinational binary-to-BCD converter (8-bit in, 12-bit BCD out) among three requesters in the calculator: operand A, operand B and result. A registered round-robin arbiter grants one requester at a time and drives the converter input. After a programmable settle time it captures the converter output and returns the BCD value, tagged with the requester id, to the display logic.

## Interface
- SETTLE_CYCLES, 1: cycles dd_in is held before dd_out is captured; legal range 1..15; 0 is illegal.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  level requests; bit i belongs to requester i
- val0, val1, val2  in  8 each  value to convert for each requester
- gnt  out  3  one-hot, one-cycle grant pulse
- dd_in  out  8  registered drive to the shared converter input
- dd_out  in  12  converter BCD result {hundreds, tens, ones}
- bcd_out  out  12  captured BCD result
- bcd_neg  out  1  sign of the captured value (BCD_SIGNED_EN only, else 0)
- bcd_id  out  2  index of the requester that owns bcd_out
- bcd_valid  out  1  one-cycle pulse; bcd_out, bcd_neg and bcd_id are valid
- busy  out  1  high while a conversion is in flight

## Operation
- States: IDLE, WAIT. Also tracks a 4-bit settle counter and a 2-bit last-granted pointer `last`.
- IDLE with req != 0: choose the first set bit searching last+1, last+2, last+3 (mod 3).
  - Register gnt = one-hot of the winner.
  - Load dd_in from the winner's value.
  - Set counter = SETTLE_CYCLES-1, set last = winner, go to WAIT.
- IDLE with req == 0: stay; gnt = 0; dd_in holds its last value.
- WAIT: busy = 1; gnt = 0; req is ignored.
  - If counter == 0: register bcd_out = dd_out and bcd_id = last, pulse bcd_valid, go to IDLE.
  - Otherwise decrement the counter.
- Requester contract: hold req and val stable until gnt is seen, then drop req.
  - A req still high in the cycle after gnt is a new request.
  - A req dropped before grant has no effect.
- bcd_out, bcd_id and bcd_neg hold their values between bcd_valid pulses.
- Reset values: state IDLE, last = 2 (requester 0 wins first), gnt 0, dd_in 0, bcd_out 0, bcd_id 0, bcd_neg 0, bcd_valid 0, busy 0.
- Reset mid-conversion aborts the conversion. No bcd_valid is produced for the aborted request.

## Timing
- req sampled in IDLE cycle N:
  - gnt and dd_in update at cycle N+1; busy is high from N+1 to N+SETTLE_CYCLES.
  - bcd_valid is high in cycle N+SETTLE_CYCLES+1, and the block is back in IDLE in that same cycle.
- That IDLE cycle samples req, so back-to-back grants are SETTLE_CYCLES+1 cycles apart.
  - SETTLE_CYCLES=1 gives one result every 2 cycles.
- gnt and bcd_valid are never high in the same cycle.
- dd_in is stable throughout WAIT. The converter is combinational, so SETTLE_CYCLES=1 is sufficient at the target clock.

## Configuration
- BCD_SIGNED_EN defined: values are two's complement.
  - If bit 7 is set, dd_in = (~val+1) & 8'hFF, so 8'h80 becomes 128.
  - The sign is registered at grant and copied to bcd_neg at capture.
- Not defined: values are unsigned, dd_in = val, and bcd_neg is tied to 0.

## Test plan
- After reset, req=3'b010, val1=8'd255 at cycle N -> gnt=3'b010 at N+1; bcd_valid at N+2 with bcd_out=12'h255, bcd_id=1.
- req=3'b111 from reset, vals 10/20/30, each requester dropping req after its gnt -> grants in order 0, 1, 2, one every 2 cycles; bcd_out = 12'h010, 12'h020, 12'h030 with bcd_id 0, 1, 2.
- req0 and req2 held high continuously -> grants alternate 0, 2, 0, 2; requester 1 is never granted; no back-to-back grant to the same requester.
- SETTLE_CYCLES=3, val0=8'd0 requested at N -> busy high N+1..N+3; bcd_valid only at N+4 with bcd_out=12'h000; dd_in stable throughout.
- Signed build: 8'hF6 -> 12'h010 with bcd_neg=1; 8'h80 -> 12'h128 with bcd_neg=1. Unsigned build: 8'hF6 -> 12'h246 with bcd_neg=0.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; no bcd_valid after release; the next request (req2) is granted before requester 0 only if req0 is low.
